// File: rtl/prco_debug_ctrl.sv
// Host-side run-control and trace capture for prco_core: drives i_mode/i_step and
// buffers one q_debug byte per retired instruction in a FIFO the host drains.
//
// state      | meaning
// HALTED     | core held in single-step mode, host commands accepted
// STEP_PULSE | q_step asserted for STEP_PULSE cycles
// STEP_WAIT  | waiting up to STEP_TIMEOUT cycles for the stepped instruction to retire
// RUNNING    | core free-running, host commands accepted
module prco_debug_ctrl #(
    parameter int TRACE_DEPTH  = 16,
    parameter int STEP_PULSE   = 2,
    parameter int STEP_TIMEOUT = 255
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_cmd_valid,
    input  logic [1:0]                     i_cmd,
    output logic                           q_cmd_ready,
    output logic                           q_mode,
    output logic                           q_step,
    input  logic                           i_debug_instr_clk,
    input  logic [7:0]                     i_debug,
    input  logic                           i_rd_en,
    output logic [7:0]                     q_rd_data,
    output logic                           q_rd_valid,
    output logic [$clog2(TRACE_DEPTH):0]   q_count,
    output logic [1:0]                     q_state,
    output logic                           q_overflow,
    output logic                           q_timeout
);
    localparam int AW   = $clog2(TRACE_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (STEP_PULSE > STEP_TIMEOUT) ? STEP_PULSE : STEP_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] FULL_C   = CW'(TRACE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] PULSE_LD = TW'(STEP_PULSE - 1);
    localparam logic [TW-1:0] WAIT_LD  = TW'(STEP_TIMEOUT - 1);

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_HALT  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_PULSE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RUN    = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            hit_q, hit_d;
    logic            prev_ic_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      mem [TRACE_DEPTH];
    logic [7:0]      rd_data_q;
    logic            rd_valid_q, ovf_q, tmo_q;

    logic retire, cmd_acc, cmd_clr, pop, push, timeout_fire;
    logic [AW-1:0] wr_addr;

    assign retire       = i_debug_instr_clk & ~prev_ic_q;
    assign cmd_acc      = i_cmd_valid & q_cmd_ready;
    assign cmd_clr      = cmd_acc & (i_cmd == CMD_CLEAR);
    assign pop          = i_rd_en & (count_q != '0);
    // A flush frees the whole FIFO, so a coincident retire always lands at slot 0.
    assign push         = retire & (cmd_clr | (count_q != FULL_C) | pop);
    assign wr_addr      = cmd_clr ? '0 : wr_ptr_q;
    assign timeout_fire = (state_q == ST_WAIT) & ~retire & (tmr_q == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_HALTED;
            tmr_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        hit_d   = hit_q;
        case (state_q)
            ST_HALTED: begin
                if (cmd_acc && i_cmd == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && i_cmd == CMD_STEP) begin
                    state_d = ST_PULSE;
                    tmr_d   = PULSE_LD;
                    hit_d   = 1'b0;
                end
            end
            ST_PULSE: begin
                if (retire) hit_d = 1'b1;
                if (tmr_q == '0) begin
                    // An early retirement already completed the step; skip the wait.
                    if (hit_q || retire) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_WAIT;
                        tmr_d   = WAIT_LD;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_WAIT: begin
                if (retire || tmr_q == '0) state_d = ST_HALTED;
                else                       tmr_d   = tmr_q - TMR_ONE;
            end
            ST_RUN: begin
                if (cmd_acc && i_cmd == CMD_HALT) state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        q_mode      = 1'b1;
        q_step      = 1'b0;
        q_cmd_ready = 1'b0;
        case (state_q)
            ST_HALTED: q_cmd_ready = 1'b1;
            ST_PULSE:  q_step      = 1'b1;
            ST_WAIT:   q_step      = 1'b0;
            ST_RUN: begin
                q_mode      = 1'b0;
                q_cmd_ready = 1'b1;
            end
            default: q_mode = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_addr] <= i_debug;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_ic_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            prev_ic_q  <= i_debug_instr_clk;
            rd_valid_q <= pop;
            if (pop) rd_data_q <= mem[rd_ptr_q];
            if (cmd_clr) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= AW'(retire);
                count_q  <= CW'(retire);
                ovf_q    <= 1'b0;
                tmo_q    <= 1'b0;
            end else begin
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (push && !pop)      count_q <= count_q + CNT_ONE;
                else if (pop && !push) count_q <= count_q - CNT_ONE;
                if (retire && !push) ovf_q <= 1'b1;
                if (timeout_fire)    tmo_q <= 1'b1;
            end
        end
    end

    assign q_state    = state_q;
    assign q_rd_data  = rd_data_q;
    assign q_rd_valid = rd_valid_q;
    assign q_count    = count_q;
    assign q_overflow = ovf_q;
    assign q_timeout  = tmo_q;

endmodule

// File: tb/tb_prco_debug_ctrl.sv
// Directed scenarios plus randomized traffic for prco_debug_ctrl, checked against a
// queue-based behavioural model of the run-control and trace FIFO rules.
module tb_prco_debug_ctrl;
    localparam int DEPTH = 16;
    localparam int SP    = 2;
    localparam int ST    = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       ic = 1'b0;
    logic [7:0] dbg = 8'h00;
    logic       rd_en = 1'b0;

    logic       q_cmd_ready, q_mode, q_step, q_rd_valid, q_overflow, q_timeout;
    logic [7:0] q_rd_data;
    logic [4:0] q_count;
    logic [1:0] q_state;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    prco_debug_ctrl #(.TRACE_DEPTH(DEPTH), .STEP_PULSE(SP), .STEP_TIMEOUT(ST)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .i_cmd(cmd), .q_cmd_ready(q_cmd_ready),
        .q_mode(q_mode), .q_step(q_step),
        .i_debug_instr_clk(ic), .i_debug(dbg),
        .i_rd_en(rd_en), .q_rd_data(q_rd_data), .q_rd_valid(q_rd_valid),
        .q_count(q_count), .q_state(q_state),
        .q_overflow(q_overflow), .q_timeout(q_timeout)
    );

    // Behavioural model: phase 0 halted, 1 pulsing, 2 waiting, 3 running.
    logic [7:0] m_q[$];
    bit   m_prev = 0, m_hit = 0, m_ovf = 0, m_tmo = 0, m_rdv = 0;
    bit   m_ret, m_acc, m_pop;
    int   m_phase = 0, m_left = 0;
    logic [7:0] m_rdd = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_prev = 0; m_hit = 0; m_ovf = 0; m_tmo = 0; m_rdv = 0;
            m_phase = 0; m_left = 0; m_rdd = 8'h00;
        end else begin
            m_ret  = ic && !m_prev;
            m_prev = ic;
            m_acc  = cmd_valid && (m_phase == 0 || m_phase == 3);
            m_pop  = rd_en && (m_q.size() > 0);
            m_rdv  = m_pop;
            if (m_pop) m_rdd = m_q[0];
            if (m_acc && cmd == 2'b11) begin
                m_q.delete();
                m_ovf = 0; m_tmo = 0;
                if (m_ret) m_q.push_back(dbg);
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_ret) begin
                    if (m_q.size() < DEPTH) m_q.push_back(dbg);
                    else m_ovf = 1;
                end
            end
            case (m_phase)
                0: if (m_acc && cmd == 2'b00) m_phase = 3;
                   else if (m_acc && cmd == 2'b01) begin m_phase = 1; m_left = SP; m_hit = 0; end
                1: begin
                    if (m_ret) m_hit = 1;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = m_hit ? 0 : 2;
                        m_left  = ST;
                    end
                end
                2: if (m_ret) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin m_tmo = 1; m_phase = 0; end
                   end
                default: if (m_acc && cmd == 2'b10) m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c);
        cmd_valid = 1'b1; cmd = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_total++; if (q_state !== 2'b00) $display("FAIL reset_state: got %b want 00", q_state); else n_pass++;
        n_total++; if (q_mode !== 1'b1) $display("FAIL reset_mode: got %b want 1", q_mode); else n_pass++;
        n_total++; if (q_step !== 1'b0) $display("FAIL reset_step: got %b want 0", q_step); else n_pass++;
        n_total++; if (q_cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", q_cmd_ready); else n_pass++;
        n_total++; if (q_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", q_count); else n_pass++;
        n_total++; if (q_rd_valid !== 1'b0 || q_rd_data !== 8'h00)
            $display("FAIL reset_rd: got v=%b d=%h want v=0 d=00", q_rd_valid, q_rd_data); else n_pass++;
        n_total++; if (q_overflow !== 1'b0 || q_timeout !== 1'b0)
            $display("FAIL reset_flags: got ovf=%b tmo=%b want 0 0", q_overflow, q_timeout); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_step();
        issue(2'b01);
        n_total++; if (q_step !== 1'b1 || q_state !== 2'b01 || q_cmd_ready !== 1'b0)
            $display("FAIL step_start: got step=%b st=%b rdy=%b want 1 01 0", q_step, q_state, q_cmd_ready); else n_pass++;
        tick();
        n_total++; if (q_step !== 1'b1) $display("FAIL step_hold: got %b want 1", q_step); else n_pass++;
        tick();
        n_total++; if (q_step !== 1'b0 || q_state !== 2'b10)
            $display("FAIL step_fall: got step=%b st=%b want 0 10", q_step, q_state); else n_pass++;
        ic = 1'b1; dbg = 8'hA5;
        tick();
        ic = 1'b0;
        n_total++; if (q_state !== 2'b00 || q_count !== 5'd1)
            $display("FAIL step_retire: got st=%b cnt=%0d want 00 1", q_state, q_count); else n_pass++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_total++; if (q_rd_valid !== 1'b1 || q_rd_data !== 8'hA5 || q_count !== 5'd0)
            $display("FAIL step_pop: got v=%b d=%h cnt=%0d want 1 a5 0", q_rd_valid, q_rd_data, q_count); else n_pass++;
        tick();
        n_total++; if (q_rd_valid !== 1'b0) $display("FAIL step_pop_pulse: got %b want 0", q_rd_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        issue(2'b00);
        n_total++; if (q_state !== 2'b11 || q_mode !== 1'b0 || q_cmd_ready !== 1'b1)
            $display("FAIL run_enter: got st=%b mode=%b rdy=%b want 11 0 1", q_state, q_mode, q_cmd_ready); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            ic = 1'b1; dbg = 8'(i);
            tick();
            ic = 1'b0;
            tick();
        end
        n_total++; if (q_count !== 5'd16 || q_overflow !== 1'b1)
            $display("FAIL ovf_full: got cnt=%0d ovf=%b want 16 1", q_count, q_overflow); else n_pass++;
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_total++; if (q_rd_valid !== 1'b1 || q_rd_data !== 8'(i))
                $display("FAIL ovf_order: got v=%b d=%h want 1 %h", q_rd_valid, q_rd_data, 8'(i)); else n_pass++;
        end
        tick();
        rd_en = 1'b0;
        n_total++; if (q_rd_valid !== 1'b0 || q_count !== 5'd0)
            $display("FAIL pop_empty: got v=%b cnt=%0d want 0 0", q_rd_valid, q_count); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        issue(2'b11);
        n_total++; if (q_count !== 5'd0 || q_overflow !== 1'b0 || q_state !== 2'b11)
            $display("FAIL clear_run: got cnt=%0d ovf=%b st=%b want 0 0 11", q_count, q_overflow, q_state); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            ic = 1'b1; dbg = 8'h40 + 8'(i);
            tick();
            ic = 1'b0;
            tick();
        end
        n_total++; if (q_count !== 5'd16 || q_overflow !== 1'b0)
            $display("FAIL fill_exact: got cnt=%0d ovf=%b want 16 0", q_count, q_overflow); else n_pass++;
        ic = 1'b1; dbg = 8'hEE; rd_en = 1'b1;
        tick();
        ic = 1'b0; rd_en = 1'b0;
        n_total++; if (q_count !== 5'd16 || q_overflow !== 1'b0 || q_rd_valid !== 1'b1 || q_rd_data !== 8'h40)
            $display("FAIL full_pushpop: got cnt=%0d ovf=%b v=%b d=%h want 16 0 1 40",
                     q_count, q_overflow, q_rd_valid, q_rd_data); else n_pass++;
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i < 15) ? 8'h41 + 8'(i) : 8'hEE;
            tick();
            n_total++; if (q_rd_data !== exp) $display("FAIL full_drain: got %h want %h", q_rd_data, exp); else n_pass++;
        end
        rd_en = 1'b0;
        issue(2'b10);
        n_total++; if (q_state !== 2'b00 || q_mode !== 1'b1)
            $display("FAIL halt: got st=%b mode=%b want 00 1", q_state, q_mode); else n_pass++;
    endtask

    task automatic test_timeout();
        int k = 0;
        int n = 0;
        issue(2'b01);
        while (q_step === 1'b1 && k < 10) begin tick(); k++; end
        n_total++; if (q_step !== 1'b0 || k != SP)
            $display("FAIL tmo_pulse: got step=%b cycles=%0d want 0 %0d", q_step, k + 1, SP + 1); else n_pass++;
        n_total++; if (q_state !== 2'b10 || q_cmd_ready !== 1'b0)
            $display("FAIL tmo_wait: got st=%b rdy=%b want 10 0", q_state, q_cmd_ready); else n_pass++;
        while (q_timeout !== 1'b1 && n < 400) begin tick(); n++; end
        n_total++; if (n != ST) $display("FAIL tmo_latency: got %0d want %0d", n, ST); else n_pass++;
        n_total++; if (q_state !== 2'b00 || q_cmd_ready !== 1'b1 || q_mode !== 1'b1)
            $display("FAIL tmo_end: got st=%b rdy=%b mode=%b want 00 1 1", q_state, q_cmd_ready, q_mode); else n_pass++;
    endtask

    task automatic test_hold_clear();
        ic = 1'b1; dbg = 8'h3C;
        repeat (5) tick();
        ic = 1'b0;
        tick();
        n_total++; if (q_count !== 5'd1) $display("FAIL hold_once: got %0d want 1", q_count); else n_pass++;
        cmd_valid = 1'b1; cmd = 2'b11; ic = 1'b1; dbg = 8'h77;
        tick();
        cmd_valid = 1'b0; ic = 1'b0;
        n_total++; if (q_count !== 5'd1 || q_timeout !== 1'b0 || q_overflow !== 1'b0)
            $display("FAIL clear_retire: got cnt=%0d tmo=%b ovf=%b want 1 0 0", q_count, q_timeout, q_overflow); else n_pass++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_total++; if (q_rd_data !== 8'h77) $display("FAIL clear_data: got %h want 77", q_rd_data); else n_pass++;
    endtask

    task automatic test_reset_mid_step();
        ic = 1'b1; dbg = 8'h11;
        tick();
        ic = 1'b0;
        issue(2'b01);
        n_total++; if (q_step !== 1'b1 || q_count !== 5'd1)
            $display("FAIL rst_pre: got step=%b cnt=%0d want 1 1", q_step, q_count); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (q_step !== 1'b0 || q_mode !== 1'b1 || q_state !== 2'b00 || q_count !== 5'd0)
            $display("FAIL rst_async: got step=%b mode=%b st=%b cnt=%0d want 0 1 00 0",
                     q_step, q_mode, q_state, q_count); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            int blk;
            int v;
            blk = c / 500;
            cmd_valid = ($urandom_range(0, 3) == 0);
            v = $urandom_range(0, 15);
            cmd = (v < 6) ? 2'b00 : (v < 11) ? 2'b01 : (v < 15) ? 2'b10 : 2'b11;
            if (blk % 2 == 0) ic = ($urandom_range(0, 2) == 0);
            else              ic = ($urandom_range(0, 199) == 0);
            dbg   = 8'($urandom);
            rd_en = (blk % 3 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            tick();
            n_total++; if (int'(q_count) != m_q.size()) $display("FAIL rnd_count: got %0d want %0d", q_count, m_q.size()); else n_pass++;
            n_total++; if (q_state !== 2'(m_phase)) $display("FAIL rnd_state: got %b want %0d", q_state, m_phase); else n_pass++;
            n_total++; if (q_rd_valid !== m_rdv) $display("FAIL rnd_rdv: got %b want %b", q_rd_valid, m_rdv); else n_pass++;
            n_total++; if (q_rd_data !== m_rdd) $display("FAIL rnd_rdd: got %h want %h", q_rd_data, m_rdd); else n_pass++;
            n_total++; if (q_overflow !== m_ovf) $display("FAIL rnd_ovf: got %b want %b", q_overflow, m_ovf); else n_pass++;
            n_total++; if (q_timeout !== m_tmo) $display("FAIL rnd_tmo: got %b want %b", q_timeout, m_tmo); else n_pass++;
            n_total++; if (q_step !== (m_phase == 1)) $display("FAIL rnd_step: got %b want %b", q_step, m_phase == 1); else n_pass++;
            n_total++; if (q_mode !== (m_phase != 3)) $display("FAIL rnd_mode: got %b want %b", q_mode, m_phase != 3); else n_pass++;
            n_total++; if (q_cmd_ready !== (m_phase == 0 || m_phase == 3))
                $display("FAIL rnd_ready: got %b want %b", q_cmd_ready, m_phase == 0 || m_phase == 3); else n_pass++;
        end
        cmd_valid = 1'b0; ic = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_step();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_hold_clear();
        test_reset_mid_step();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
